// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port DataMemory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface data_mem_arbiter_if #(
    parameter int WORD     = 16,
    parameter int ADDRESSL = 10
);
    logic                reqA;
    logic                reqB;
    logic                weA;
    logic                weB;
    logic [ADDRESSL-1:0] addrA;
    logic [ADDRESSL-1:0] addrB;
    logic [WORD-1:0]     wdataA;
    logic [WORD-1:0]     wdataB;
    logic                gntA;
    logic                gntB;
    logic                rvalidA;
    logic                rvalidB;
    logic [WORD-1:0]     rdataA;
    logic [WORD-1:0]     rdataB;
    logic [ADDRESSL-1:0] memAddress;
    logic [WORD-1:0]     memWriteData;
    logic                memWrite;
    logic                memRead;
    logic [WORD-1:0]     memReadData;

    modport slave (
        input  reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, memReadData,
        output gntA, gntB, rvalidA, rvalidB, rdataA, rdataB,
               memAddress, memWriteData, memWrite, memRead
    );

    modport master (
        output reqA, reqB, weA, weB, addrA, addrB, wdataA, wdataB, memReadData,
        input  gntA, gntB, rvalidA, rvalidB, rdataA, rdataB,
               memAddress, memWriteData, memWrite, memRead
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the single-port DataMemory. One access at a time:
// IDLE picks a winner (round-robin or fixed A priority), ACCESS holds the registered
// memory command for WAIT_STATES+1 cycles, and reads return through a one-cycle
// rvalid pulse with rdata held until the next read on that port.
module data_mem_arbiter #(
    parameter int WORD        = 16,
    parameter int ADDRESSL    = 10,
    parameter int WAIT_STATES = 0,
    parameter int FIXED_PRIO  = 0
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              r_state;
    logic [3:0]          r_waitCnt;
    logic                r_lastB;
    logic                r_selB;
    logic                r_gntA;
    logic                r_gntB;
    logic                r_rvalidA;
    logic                r_rvalidB;
    logic [WORD-1:0]     r_rdataA;
    logic [WORD-1:0]     r_rdataB;
    logic [ADDRESSL-1:0] r_memAddress;
    logic [WORD-1:0]     r_memWriteData;
    logic                r_memWrite;
    logic                r_memRead;

    logic                w_pickB;
    logic                w_we;
    logic [ADDRESSL-1:0] w_addr;
    logic [WORD-1:0]     w_wdata;

    // B wins when it is alone, or on a tie when round-robin says A went last.
    assign w_pickB = bus.reqB && (!bus.reqA || (FIXED_PRIO == 0 && !r_lastB));
    assign w_we    = w_pickB ? bus.weB    : bus.weA;
    assign w_addr  = w_pickB ? bus.addrB  : bus.addrA;
    assign w_wdata = w_pickB ? bus.wdataB : bus.wdataA;

    // Arbitration FSM; every output is registered here and cleared by the async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_waitCnt      <= '0;
            r_lastB        <= 1'b1;
            r_selB         <= 1'b0;
            r_gntA         <= 1'b0;
            r_gntB         <= 1'b0;
            r_rvalidA      <= 1'b0;
            r_rvalidB      <= 1'b0;
            r_rdataA       <= '0;
            r_rdataB       <= '0;
            r_memAddress   <= '0;
            r_memWriteData <= '0;
            r_memWrite     <= 1'b0;
            r_memRead      <= 1'b0;
        end else begin
            r_rvalidA <= 1'b0;
            r_rvalidB <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.reqA || bus.reqB) begin
                        r_selB         <= w_pickB;
                        r_lastB        <= w_pickB;
                        r_gntA         <= !w_pickB;
                        r_gntB         <= w_pickB;
                        r_memAddress   <= w_addr;
                        r_memWriteData <= w_wdata;
                        r_memWrite     <= w_we;
                        r_memRead      <= !w_we;
                        r_waitCnt      <= 4'(WAIT_STATES);
                        r_state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (r_waitCnt != 4'd0) begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end else begin
                        r_gntA     <= 1'b0;
                        r_gntB     <= 1'b0;
                        r_memWrite <= 1'b0;
                        r_memRead  <= 1'b0;
                        r_state    <= IDLE;
                        // Memory read is combinational, so the data is valid on this final edge.
                        if (r_memRead) begin
                            if (r_selB) begin
                                r_rdataB  <= bus.memReadData;
                                r_rvalidB <= 1'b1;
                            end else begin
                                r_rdataA  <= bus.memReadData;
                                r_rvalidA <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gntA         = r_gntA;
    assign bus.gntB         = r_gntB;
    assign bus.rvalidA      = r_rvalidA;
    assign bus.rvalidB      = r_rvalidB;
    assign bus.rdataA       = r_rdataA;
    assign bus.rdataB       = r_rdataB;
    assign bus.memAddress   = r_memAddress;
    assign bus.memWriteData = r_memWriteData;
    assign bus.memWrite     = r_memWrite;
    assign bus.memRead      = r_memRead;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: four instances cover round-robin, fixed priority,
// wait states and reset during an access. Instance 0 also runs randomized traffic
// against a shadow memory and a round-robin winner model.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic rst3;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.WORD(16), .ADDRESSL(10)) b0 ();
    data_mem_arbiter_if #(.WORD(16), .ADDRESSL(10)) b1 ();
    data_mem_arbiter_if #(.WORD(16), .ADDRESSL(10)) b2 ();
    data_mem_arbiter_if #(.WORD(16), .ADDRESSL(10)) b3 ();

    data_mem_arbiter #(.WORD(16), .ADDRESSL(10), .WAIT_STATES(0), .FIXED_PRIO(0)) u0 (.clk(clk), .rst(rst),  .bus(b0));
    data_mem_arbiter #(.WORD(16), .ADDRESSL(10), .WAIT_STATES(0), .FIXED_PRIO(1)) u1 (.clk(clk), .rst(rst),  .bus(b1));
    data_mem_arbiter #(.WORD(16), .ADDRESSL(10), .WAIT_STATES(2), .FIXED_PRIO(0)) u2 (.clk(clk), .rst(rst),  .bus(b2));
    data_mem_arbiter #(.WORD(16), .ADDRESSL(10), .WAIT_STATES(3), .FIXED_PRIO(0)) u3 (.clk(clk), .rst(rst3), .bus(b3));

    // Memory model for instance 0, with a preload path used while in reset
    logic [15:0] m0 [1024];
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [15:0] ld_data;
    assign b0.memReadData = m0[b0.memAddress];
    always @(posedge clk) begin
        if (ld_en) m0[ld_addr] <= ld_data;
        else if (b0.memWrite) m0[b0.memAddress] <= b0.memWriteData;
    end
    assign b1.memReadData = 16'h00C3;
    assign b2.memReadData = {6'b110000, b2.memAddress};
    assign b3.memReadData = 16'hA5A5;

    // Reference state for instance 0
    logic [15:0] sh0 [1024];
    bit          lastB_m;
    bit          cwe  [2];
    logic [9:0]  cad  [2];
    logic [15:0] cdat [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_req0(input bit p, input bit we, input logic [9:0] a, input logic [15:0] d);
        cwe[p] = we; cad[p] = a; cdat[p] = d;
        if (p) begin b0.reqB = 1'b1; b0.weB = we; b0.addrB = a; b0.wdataB = d; end
        else   begin b0.reqA = 1'b1; b0.weA = we; b0.addrA = a; b0.wdataA = d; end
    endtask

    // Called just after a negedge of an idle cycle with port p's request pending and winning.
    task automatic serve0(input bit p);
        @(posedge clk); #1;
        if (p) begin b0.addrB = ~cad[1]; b0.wdataB = ~cdat[1]; b0.weB = ~cwe[1]; end
        else   begin b0.addrA = ~cad[0]; b0.wdataA = ~cdat[0]; b0.weA = ~cwe[0]; end
        @(negedge clk);
        chk("u0 acc gntA", b0.gntA, !p);
        chk("u0 acc gntB", b0.gntB, p);
        chk("u0 acc memRead", b0.memRead, !cwe[p]);
        chk("u0 acc memWrite", b0.memWrite, cwe[p]);
        chk("u0 acc memAddress", b0.memAddress, cad[p]);
        if (cwe[p]) chk("u0 acc memWriteData", b0.memWriteData, cdat[p]);
        chk("u0 acc rvalidA", b0.rvalidA, 0);
        chk("u0 acc rvalidB", b0.rvalidB, 0);
        @(posedge clk); #1;
        if (p) b0.reqB = 1'b0; else b0.reqA = 1'b0;
        @(negedge clk);
        chk("u0 idle gntA", b0.gntA, 0);
        chk("u0 idle gntB", b0.gntB, 0);
        chk("u0 idle memRead", b0.memRead, 0);
        chk("u0 idle memWrite", b0.memWrite, 0);
        chk("u0 idle rvalidA", b0.rvalidA, (!p && !cwe[p]));
        chk("u0 idle rvalidB", b0.rvalidB, (p && !cwe[p]));
        if (!cwe[p]) begin
            if (p) chk("u0 rdataB", b0.rdataB, sh0[cad[p]]);
            else   chk("u0 rdataA", b0.rdataA, sh0[cad[p]]);
        end else begin
            sh0[cad[p]] = cdat[p];
        end
        lastB_m = p;
    endtask

    initial begin
        logic [9:0]  a;
        logic [15:0] v;
        bit          we;
        int          mode;
        bit          w;

        rst = 1'b0; rst3 = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        b0.reqA = 0; b0.reqB = 0; b0.weA = 0; b0.weB = 0; b0.addrA = 0; b0.addrB = 0; b0.wdataA = 0; b0.wdataB = 0;
        b1.reqA = 0; b1.reqB = 0; b1.weA = 0; b1.weB = 0; b1.addrA = 0; b1.addrB = 0; b1.wdataA = 0; b1.wdataB = 0;
        b2.reqA = 0; b2.reqB = 0; b2.weA = 0; b2.weB = 0; b2.addrA = 0; b2.addrB = 0; b2.wdataA = 0; b2.wdataB = 0;
        b3.reqA = 0; b3.reqB = 0; b3.weA = 0; b3.weB = 0; b3.addrA = 0; b3.addrB = 0; b3.wdataA = 0; b3.wdataB = 0;
        lastB_m = 1'b1;

        // Preload the addresses used by instance 0 while everything is in reset
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            a = (i < 16) ? 10'(i) : 10'h3FF;
            v = (a == 10'd5) ? 16'h1234 : 16'($urandom);
            ld_addr = a; ld_data = v; ld_en = 1'b1; sh0[a] = v;
            @(negedge clk);
        end
        ld_en = 1'b0;

        // Reset state
        chk("rst gntA", b0.gntA, 0);
        chk("rst gntB", b0.gntB, 0);
        chk("rst rvalidA", b0.rvalidA, 0);
        chk("rst rvalidB", b0.rvalidB, 0);
        chk("rst rdataA", b0.rdataA, 0);
        chk("rst rdataB", b0.rdataB, 0);
        chk("rst memAddress", b0.memAddress, 0);
        chk("rst memWriteData", b0.memWriteData, 0);
        chk("rst memWrite", b0.memWrite, 0);
        chk("rst memRead", b0.memRead, 0);
        rst = 1'b1; rst3 = 1'b1;
        @(negedge clk);
        chk("idle after reset gntA", b0.gntA, 0);

        // Both held, round-robin: A,B,A,B
        set_req0(0, 0, 10'd1, 16'h0);
        set_req0(1, 1, 10'd2, 16'h1111);
        serve0(0);
        set_req0(0, 0, 10'd2, 16'h0);
        serve0(1);
        set_req0(1, 0, 10'd1, 16'h0);
        serve0(0);
        serve0(1);

        // Read A at 5 returns 1234
        set_req0(0, 0, 10'h005, 16'h0);
        serve0(0);
        chk("read5 rdataA", b0.rdataA, 16'h1234);

        // Write B to 3FF then read it back on A
        set_req0(1, 1, 10'h3FF, 16'hBEEF);
        serve0(1);
        set_req0(0, 0, 10'h3FF, 16'h0);
        serve0(0);
        chk("readback rdataA", b0.rdataA, 16'hBEEF);

        // Request withdrawn before any edge sees it
        b0.reqA = 1'b1; b0.weA = 1'b1; b0.addrA = 10'd3;
        #2 b0.reqA = 1'b0;
        @(negedge clk);
        chk("dropped gntA", b0.gntA, 0);
        chk("dropped memWrite", b0.memWrite, 0);

        // Randomized traffic against the shadow memory
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            for (int p = 0; p < 2; p++) begin
                if (mode == 2 || mode == p) begin
                    a  = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15));
                    we = 1'($urandom_range(0, 1));
                    set_req0(1'(p), we, a, 16'($urandom));
                end
            end
            if (mode == 2) begin
                w = lastB_m ? 1'b0 : 1'b1;
                serve0(w);
                serve0(!w);
            end else begin
                serve0(1'(mode));
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                chk("u0 gap gntA", b0.gntA, 0);
                chk("u0 gap gntB", b0.gntB, 0);
            end
        end

        // Fixed priority: A wins four times while both are held, then B
        b1.reqA = 1'b1; b1.reqB = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            chk("u1 acc gntA", b1.gntA, 1);
            chk("u1 acc gntB", b1.gntB, 0);
            @(posedge clk); #1;
            if (k == 3) b1.reqA = 1'b0;
            @(negedge clk);
            chk("u1 idle gntA", b1.gntA, 0);
            chk("u1 idle rvalidA", b1.rvalidA, 1);
        end
        chk("u1 rdataA", b1.rdataA, 16'h00C3);
        @(posedge clk); @(negedge clk);
        chk("u1 late gntB", b1.gntB, 1);
        chk("u1 late gntA", b1.gntA, 0);
        @(posedge clk); #1 b1.reqB = 1'b0;
        @(negedge clk);
        chk("u1 rvalidB", b1.rvalidB, 1);

        // Two wait states: three ACCESS cycles, rvalid in the fourth
        b2.reqA = 1'b1; b2.weA = 1'b0; b2.addrA = 10'h077;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            chk("u2 gntA", b2.gntA, 1);
            chk("u2 memRead", b2.memRead, 1);
            chk("u2 memAddress", b2.memAddress, 10'h077);
            chk("u2 rvalidA early", b2.rvalidA, 0);
        end
        @(posedge clk); #1 b2.reqA = 1'b0;
        @(negedge clk);
        chk("u2 end gntA", b2.gntA, 0);
        chk("u2 end memRead", b2.memRead, 0);
        chk("u2 rvalidA", b2.rvalidA, 1);
        chk("u2 rdataA", b2.rdataA, 16'hC077);
        @(negedge clk);
        chk("u2 rvalidA pulse", b2.rvalidA, 0);
        chk("u2 rdataA held", b2.rdataA, 16'hC077);

        // Reset in the middle of a WAIT_STATES=3 access
        b3.reqA = 1'b1; b3.weA = 1'b0; b3.addrA = 10'h012;
        @(posedge clk); @(negedge clk);
        chk("u3 gntA", b3.gntA, 1);
        @(posedge clk); @(negedge clk);
        #1 rst3 = 1'b0;
        #1;
        chk("u3 abort gntA", b3.gntA, 0);
        chk("u3 abort gntB", b3.gntB, 0);
        chk("u3 abort memRead", b3.memRead, 0);
        chk("u3 abort memWrite", b3.memWrite, 0);
        chk("u3 abort memAddress", b3.memAddress, 0);
        chk("u3 abort rvalidA", b3.rvalidA, 0);
        chk("u3 abort rdataA", b3.rdataA, 0);
        b3.reqB = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("u3 in reset rvalidA", b3.rvalidA, 0);
        end
        #1 rst3 = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("u3 after reset gntA", b3.gntA, 1);
        chk("u3 after reset gntB", b3.gntB, 0);
        chk("u3 after reset rvalidA", b3.rvalidA, 0);
        b3.reqA = 1'b0; b3.reqB = 1'b0;
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
